// File: rtl/immediate_formatter_if.sv
// Character-stream bundle between a formatting requester and the immediate formatter.
// The requester drives start/options and char_ready; the formatter drives the character side.
interface immediate_formatter_if;
  logic        start;
  logic [31:0] value;
  logic        suppress_zeros;
  logic        use_comma;
  logic [7:0]  ascii_out;
  logic        char_valid;
  logic        char_ready;
  logic        busy_flag;
  logic        done_flag;

  modport master (
    output start, value, suppress_zeros, use_comma, char_ready,
    input  ascii_out, char_valid, busy_flag, done_flag
  );

  modport slave (
    input  start, value, suppress_zeros, use_comma, char_ready,
    output ascii_out, char_valid, busy_flag, done_flag
  );
endinterface

// File: rtl/immediate_formatter.sv
// Turns a 32-bit immediate into the ASCII stream "0x<hex digits><delimiter>",
// one character per valid/ready transfer, re-parsable by the assembler.
module immediate_formatter #(
  parameter bit LOWERCASE = 1'b0,
  parameter int DIGITS    = 8
) (
  input logic clk_in,
  input logic rst_in,
  immediate_formatter_if.slave fmt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFIX0,
    S_PREFIX_X,
    S_DIGITS,
    S_DELIM,
    S_DONE
  } state_t;

  localparam logic [31:0] VALUE_MASK =
    (DIGITS >= 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * DIGITS)) - 32'd1);

  state_t      state_q;
  logic [31:0] shift_q;
  logic [3:0]  count_q;
  logic        comma_q;
  logic [7:0]  ascii_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic [31:0] masked_d;
  logic [3:0]  count_d;
  logic [31:0] shift_d;

  function automatic logic [7:0] hexChar(input logic [3:0] nibble);
    if (nibble < 4'd10) return 8'h30 + {4'h0, nibble};
    return (LOWERCASE ? 8'h57 : 8'h37) + {4'h0, nibble};
  endfunction

  // Capture-time digit count and left-aligned shift image, so the first
  // emitted digit always sits in the top nibble.
  always_comb begin
    masked_d = fmt.value & VALUE_MASK;
    count_d  = fmt.suppress_zeros ? 4'd1 : 4'(DIGITS);
    if (fmt.suppress_zeros) begin
      for (int i = 1; i < 8; i++) begin
        if (masked_d[4*i +: 4] != 4'h0) count_d = 4'(i + 1);
      end
    end
    shift_d = masked_d << {4'd8 - count_d, 2'b00};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      count_q <= '0;
      comma_q <= 1'b0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (fmt.start) begin
            shift_q <= shift_d;
            count_q <= count_d;
            comma_q <= fmt.use_comma;
            ascii_q <= 8'h30;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_PREFIX0;
          end
        end
        S_PREFIX0: begin
          if (fmt.char_ready) begin
            ascii_q <= 8'h78;
            state_q <= S_PREFIX_X;
          end
        end
        S_PREFIX_X: begin
          if (fmt.char_ready) begin
            ascii_q <= hexChar(shift_q[31:28]);
            state_q <= S_DIGITS;
          end
        end
        S_DIGITS: begin
          if (fmt.char_ready) begin
            shift_q <= shift_q << 4;
            count_q <= count_q - 4'd1;
            if (count_q == 4'd1) begin
              ascii_q <= comma_q ? 8'h2C : 8'h20;
              state_q <= S_DELIM;
            end else begin
              ascii_q <= hexChar(shift_q[27:24]);
            end
          end
        end
        S_DELIM: begin
          if (fmt.char_ready) begin
            ascii_q <= 8'h00;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign fmt.ascii_out  = ascii_q;
  assign fmt.char_valid = valid_q;
  assign fmt.busy_flag  = busy_q;
  assign fmt.done_flag  = done_q;

endmodule
